// File: rtl/addsub_settle_monitor_pkg.sv
// Shared types for the add/sub settle monitor: FSM states, the per-vector record
// and a helper that validates the window / counter width pairing.
package addsub_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WATCH,
        DONE
    } state_t;

    localparam int REC_CNT_W = 8;

    typedef struct packed {
        logic [REC_CNT_W-1:0] settle;
        logic                 mismatch;
    } rec_t;

    // The settle count reaches WINDOW, so the counter must hold that value.
    function automatic bit cnt_w_fits(input int window, input int cnt_w);
        return (window >= 2) && ((64'd1 << cnt_w) > 64'(window));
    endfunction

endpackage

// File: rtl/addsub_settle_monitor_if.sv
// Bundle of stimulus echo, DUT response and record handshake seen by the settle monitor.
// master = harness/sink side, slave = monitor side.
interface addsub_settle_monitor_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic             apply;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic [WIDTH-1:0] ans;
    logic             cout;
    logic             v;
    logic             rec_valid;
    logic             rec_ready;
    logic [CNT_W-1:0] rec_settle;
    logic             rec_mismatch;
    logic             busy;
    logic             overrun;
    logic [31:0]      vec_count;

    modport master (
        output apply, a, b, sub, ans, cout, v, rec_ready,
        input  rec_valid, rec_settle, rec_mismatch, busy, overrun, vec_count
    );

    modport slave (
        input  apply, a, b, sub, ans, cout, v, rec_ready,
        output rec_valid, rec_settle, rec_mismatch, busy, overrun, vec_count
    );
endinterface

// File: rtl/addsub_settle_monitor_golden.sv
// Combinational reference adder/subtractor used to judge the observed DUT result.
module addsub_golden #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             v
);
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   total;

    // Subtraction is a + ~b + 1, so carry-out means "no borrow".
    always_comb begin
        b_eff = sub ? ~b : b;
        total = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        sum   = total[WIDTH-1:0];
        cout  = total[WIDTH];
        v     = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end
endmodule

// File: rtl/addsub_settle_monitor.sv
// Watches the adder/subtractor outputs for WINDOW cycles after each vector and emits a
// settle/mismatch record. Define ADDSUB_CHECK_EN to build the golden-model comparison.
module addsub_settle_monitor
    import addsub_mon_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int WINDOW = 100,
    parameter int CNT_W  = REC_CNT_W
) (
    input logic clk,
    input logic rst,
    addsub_settle_monitor_if.slave bus
);
    generate
        if (!cnt_w_fits(WINDOW, CNT_W) || (CNT_W != REC_CNT_W)) begin : g_bad_cfg
            $error("addsub_settle_monitor: WINDOW must be >= 2 and fit in CNT_W bits");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(WINDOW - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] k;
    logic [CNT_W-1:0] k_inc;
    logic [CNT_W-1:0] last;
    logic [WIDTH+1:0] prev;
    logic [WIDTH+1:0] sample;
    rec_t             rec;
    logic [31:0]      vec_count;
    logic             overrun;
    logic             handshake;
    logic             start;
    logic             apply_lost;
    logic             changed;
    logic             mismatch_now;

    assign sample     = {bus.ans, bus.cout, bus.v};
    assign k_inc      = k + CNT_W'(1);
    assign changed    = (sample != prev);
    assign handshake  = (state == DONE) && bus.rec_ready;
    assign start      = bus.apply && ((state == IDLE) || handshake);
    assign apply_lost = bus.apply && ((state == WATCH) || ((state == DONE) && !bus.rec_ready));

`ifdef ADDSUB_CHECK_EN
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sub;
    logic [WIDTH-1:0] gold_sum;
    logic             gold_cout;
    logic             gold_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            op_sub <= 1'b0;
        end else if (start) begin
            op_a   <= bus.a;
            op_b   <= bus.b;
            op_sub <= bus.sub;
        end
    end

    addsub_golden #(.WIDTH(WIDTH)) u_golden (
        .a    (op_a),
        .b    (op_b),
        .sub  (op_sub),
        .sum  (gold_sum),
        .cout (gold_cout),
        .v    (gold_v)
    );

    assign mismatch_now = (sample != {gold_sum, gold_cout, gold_v});
`else
    assign mismatch_now = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.apply) state_next = WATCH;
            WATCH:   if (k_inc == LAST_K) state_next = DONE;
            DONE:    if (bus.rec_ready) state_next = bus.apply ? WATCH : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The final window cycle still compares, so its change must count toward settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            k         <= '0;
            last      <= '0;
            prev      <= '0;
            rec       <= '0;
            vec_count <= '0;
            overrun   <= 1'b0;
        end else begin
            if (start) begin
                k    <= '0;
                last <= '0;
                prev <= sample;
            end else if (state == WATCH) begin
                k <= k_inc;
                if (changed) begin
                    last <= k_inc;
                    prev <= sample;
                end
                if (k_inc == LAST_K) begin
                    rec.settle   <= (changed ? k_inc : last) + CNT_W'(1);
                    rec.mismatch <= mismatch_now;
                end
            end
            if (handshake) vec_count <= vec_count + 32'd1;
            if (apply_lost) overrun <= 1'b1;
        end
    end

    always_comb begin
        bus.rec_valid    = (state == DONE);
        bus.busy         = (state != IDLE);
        bus.rec_settle   = rec.settle;
        bus.rec_mismatch = rec.mismatch;
        bus.overrun      = overrun;
        bus.vec_count    = vec_count;
    end
endmodule

// File: tb/tb_addsub_settle_monitor.sv
// Randomised self-checking bench for addsub_settle_monitor; the reference model derives
// settle time and golden result directly from the recorded sample trace.
module tb_addsub_settle_monitor;
    localparam int WIDTH  = 32;
    localparam int WINDOW = 100;
    localparam int CNT_W  = 8;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    int   exp_count;
    logic [WIDTH+1:0] smp [WINDOW];

    addsub_settle_monitor_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    addsub_settle_monitor #(.WIDTH(WIDTH), .WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH+1:0] gold_tuple(input logic [31:0] a, input logic [31:0] b,
                                                    input logic sub);
        longint     r;
        logic [31:0] s;
        logic        c;
        logic        ov;
        r  = sub ? (longint'($signed(a)) - longint'($signed(b)))
                 : (longint'($signed(a)) + longint'($signed(b)));
        ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        s  = sub ? (a - b) : (a + b);
        c  = sub ? (a >= b) : (({32'd0, a} + {32'd0, b}) > 64'h0000_0000_FFFF_FFFF);
        return {s, c, ov};
    endfunction

    function automatic logic model_mismatch(input logic [31:0] a, input logic [31:0] b,
                                            input logic sub);
`ifdef ADDSUB_CHECK_EN
        return smp[WINDOW-1] !== gold_tuple(a, b, sub);
`else
        return (a === 32'hx) && (b === 32'hx) && (sub === 1'bx);
`endif
    endfunction

    function automatic int model_settle();
        int last_change;
        last_change = 0;
        for (int j = 1; j < WINDOW; j++) begin
            if (smp[j] !== smp[j-1]) last_change = j;
        end
        return last_change + 1;
    endfunction

    task automatic fill_const(input logic [WIDTH+1:0] val);
        for (int j = 0; j < WINDOW; j++) smp[j] = val;
    endtask

    task automatic run_vector(input logic [31:0] a, input logic [31:0] b, input logic sub,
                              input bit with_ready, input string name);
        logic [CNT_W-1:0] exp_settle;
        logic             exp_mis;
        exp_settle = CNT_W'(model_settle());
        exp_mis    = model_mismatch(a, b, sub);
        for (int j = 0; j < WINDOW; j++) begin
            bus.apply     = (j == 0);
            bus.rec_ready = with_ready && (j == 0);
            if (j == 0) begin
                bus.a   = a;
                bus.b   = b;
                bus.sub = sub;
            end
            {bus.ans, bus.cout, bus.v} = smp[j];
            tick();
            if (j == 0 && with_ready) begin
                exp_count++;
                tests_run++;
                if (bus.vec_count !== 32'(exp_count)) begin
                    tests_failed++;
                    $display("[TB] FAIL %s b2b_count: got %0d expected %0d", name, bus.vec_count, exp_count);
                end
                tests_run++;
                if (bus.busy !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL %s b2b_busy: got %b expected 1", name, bus.busy);
                end
            end
            if (j == WINDOW - 2) begin
                tests_run++;
                if (bus.rec_valid !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL %s early_valid: got %b expected 0", name, bus.rec_valid);
                end
            end
        end
        bus.apply     = 1'b0;
        bus.rec_ready = 1'b0;
        tests_run++;
        if (bus.rec_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL %s valid: got %b expected 1", name, bus.rec_valid);
        end
        tests_run++;
        if (bus.rec_settle !== exp_settle) begin
            tests_failed++;
            $display("[TB] FAIL %s settle: got %0d expected %0d", name, bus.rec_settle, exp_settle);
        end
        tests_run++;
        if (bus.rec_mismatch !== exp_mis) begin
            tests_failed++;
            $display("[TB] FAIL %s mismatch: got %b expected %b", name, bus.rec_mismatch, exp_mis);
        end
    endtask

    task automatic accept(input string name);
        bus.rec_ready = 1'b1;
        tick();
        bus.rec_ready = 1'b0;
        exp_count++;
        tests_run++;
        if (bus.vec_count !== 32'(exp_count)) begin
            tests_failed++;
            $display("[TB] FAIL %s count: got %0d expected %0d", name, bus.vec_count, exp_count);
        end
        tests_run++;
        if (bus.rec_valid !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s release: got valid=%b busy=%b expected 0/0", name, bus.rec_valid, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.apply = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0;
        bus.ans = '0; bus.cout = 1'b0; bus.v = 1'b0; bus.rec_ready = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (bus.rec_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.rec_valid); end
        tests_run++;
        if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        tests_run++;
        if (bus.overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_overrun: got %b expected 0", bus.overrun); end
        tests_run++;
        if (bus.vec_count !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.vec_count); end
        tests_run++;
        if (bus.rec_settle !== '0 || bus.rec_mismatch !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_record: got settle=%0d mis=%b expected 0/0", bus.rec_settle, bus.rec_mismatch);
        end
        rst = 1'b0;
        exp_count = 0;
        tick();
    endtask

    task automatic test_stable();
        fill_const({32'd8, 1'b0, 1'b0});
        run_vector(32'd5, 32'd3, 1'b0, 1'b0, "stable");
        accept("stable");
    endtask

    task automatic test_settle_points();
        fill_const({32'd1, 1'b0, 1'b0});
        for (int j = 3; j < WINDOW; j++) smp[j] = {32'd2, 1'b1, 1'b0};
        for (int j = 12; j < WINDOW; j++) smp[j] = {32'd3, 1'b0, 1'b1};
        run_vector(32'd1, 32'd2, 1'b0, 1'b0, "settle13");
        accept("settle13");
        fill_const({32'hABCD0000, 1'b0, 1'b0});
        smp[WINDOW-1] = {32'hABCD0001, 1'b0, 1'b0};
        run_vector(32'hABCD0000, 32'd1, 1'b0, 1'b0, "settle_last");
        accept("settle_last");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        int          tail;
        for (int n = 0; n < 8; n++) begin
            a   = $urandom();
            b   = $urandom();
            sub = 1'($urandom_range(0, 1));
            smp[0] = {$urandom(), 2'($urandom_range(0, 3))};
            for (int j = 1; j < WINDOW; j++) begin
                smp[j] = ($urandom_range(0, 15) == 0) ? {$urandom(), 2'($urandom_range(0, 3))} : smp[j-1];
            end
            if ($urandom_range(0, 1) == 1) begin
                tail = $urandom_range(1, WINDOW - 1);
                for (int j = tail; j < WINDOW; j++) smp[j] = gold_tuple(a, b, sub);
            end
            run_vector(a, b, sub, 1'b0, "random");
            accept("random");
        end
    endtask

    task automatic test_hold_overrun();
        logic [CNT_W-1:0] held_settle;
        logic             held_mis;
        tests_run++;
        if (bus.overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL overrun_pre: got %b expected 0", bus.overrun); end
        fill_const({32'd10, 1'b0, 1'b0});
        for (int j = 40; j < WINDOW; j++) smp[j] = {32'd7, 1'b1, 1'b0};
        run_vector(32'd9, 32'd2, 1'b1, 1'b0, "hold");
        held_settle = CNT_W'(model_settle());
        held_mis    = model_mismatch(32'd9, 32'd2, 1'b1);
        for (int c = 0; c < 5; c++) begin
            bus.apply     = (c == 2);
            bus.rec_ready = 1'b0;
            tick();
            tests_run++;
            if (bus.rec_valid !== 1'b1 || bus.rec_settle !== held_settle || bus.rec_mismatch !== held_mis) begin
                tests_failed++;
                $display("[TB] FAIL hold_record: got v=%b s=%0d m=%b expected 1/%0d/%b",
                         bus.rec_valid, bus.rec_settle, bus.rec_mismatch, held_settle, held_mis);
            end
        end
        bus.apply = 1'b0;
        tests_run++;
        if (bus.overrun !== 1'b1) begin tests_failed++; $display("[TB] FAIL overrun_done: got %b expected 1", bus.overrun); end
        fill_const({32'd4, 1'b0, 1'b0});
        for (int j = 25; j < WINDOW; j++) smp[j] = {32'd5, 1'b0, 1'b0};
        run_vector(32'd2, 32'd3, 1'b0, 1'b1, "b2b");
        accept("b2b");
    endtask

    task automatic test_golden();
        fill_const({32'h80000000, 1'b0, 1'b1});
        run_vector(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, "gold_ovf");
        accept("gold_ovf");
        fill_const({32'h80000000, 1'b0, 1'b0});
        run_vector(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, "gold_bad_v");
        accept("gold_bad_v");
        fill_const({32'hFFFFFFFF, 1'b0, 1'b0});
        run_vector(32'd0, 32'd1, 1'b1, 1'b0, "gold_sub");
        accept("gold_sub");
    endtask

    task automatic test_reset_midwatch();
        int valid_seen;
        fill_const({32'd6, 1'b1, 1'b0});
        bus.a = 32'd3; bus.b = 32'd3; bus.sub = 1'b0;
        for (int j = 0; j <= 50; j++) begin
            bus.apply = (j == 0) || (j == 20);
            rst       = (j == 50);
            {bus.ans, bus.cout, bus.v} = smp[j];
            tick();
            if (j == 20) begin
                tests_run++;
                if (bus.overrun !== 1'b1) begin tests_failed++; $display("[TB] FAIL overrun_watch: got %b expected 1", bus.overrun); end
            end
        end
        rst = 1'b0;
        bus.apply = 1'b0;
        exp_count = 0;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.rec_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_state: got busy=%b valid=%b expected 0/0", bus.busy, bus.rec_valid);
        end
        tests_run++;
        if (bus.vec_count !== 32'd0 || bus.overrun !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_regs: got count=%0d overrun=%b expected 0/0", bus.vec_count, bus.overrun);
        end
        valid_seen = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (bus.rec_valid !== 1'b0 || bus.busy !== 1'b0) valid_seen++;
        end
        tests_run++;
        if (valid_seen != 0) begin tests_failed++; $display("[TB] FAIL midrst_quiet: got %0d active cycles expected 0", valid_seen); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_count    = 0;
        test_reset();
        test_stable();
        test_settle_points();
        test_random();
        test_hold_overrun();
        test_golden();
        test_reset_midwatch();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
